// File: rtl/div_iter.sv
// Radix-2 restoring 32-bit divider (DIV/DIVU): result_o = {remainder, quotient}.
// Optional define DIV_FAST_PATH_EN: short-circuit when |dividend| < |divisor|.
module div_iter (
  input  logic        clk,
  input  logic        resetn,
  input  logic        signed_div_i,
  input  logic [31:0] opdata1_i,
  input  logic [31:0] opdata2_i,
  input  logic        start_i,
  input  logic        annul_i,
  output logic [63:0] result_o,
  output logic        ready_o
);

  typedef enum logic [1:0] {S_IDLE, S_DIVZERO, S_BUSY, S_END} state_t;

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] dq_q, dq_d;      // dividend bits shift out the top, quotient bits in at the bottom
  logic [31:0] dvsr_q, dvsr_d;
  logic [31:0] rem_q, rem_d;
  logic        neg1_q, neg1_d;
  logic        neg2_q, neg2_d;
  logic [63:0] result_q, result_d;
  logic        ready_q, ready_d;

  logic [31:0] mag1, mag2;
  logic [32:0] rem_sh;
  logic        ge;

  function automatic logic [31:0] neg_if(input logic n, input logic [31:0] v);
    neg_if = n ? (~v + 32'd1) : v;
  endfunction

  assign mag1   = neg_if(signed_div_i & opdata1_i[31], opdata1_i);
  assign mag2   = neg_if(signed_div_i & opdata2_i[31], opdata2_i);
  assign rem_sh = {rem_q, dq_q[31]};
  assign ge     = (rem_sh >= {1'b0, dvsr_q});

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    dq_d     = dq_q;
    dvsr_d   = dvsr_q;
    rem_d    = rem_q;
    neg1_d   = neg1_q;
    neg2_d   = neg2_q;
    result_d = result_q;
    ready_d  = ready_q;
    case (state_q)
      S_IDLE: begin
        if (start_i && !annul_i) begin
          neg1_d = signed_div_i & opdata1_i[31];
          neg2_d = signed_div_i & opdata2_i[31];
          dq_d   = mag1;
          dvsr_d = mag2;
          rem_d  = 32'd0;
          cnt_d  = 6'd0;
          if (opdata2_i == 32'd0) begin
            state_d = S_DIVZERO;
`ifdef DIV_FAST_PATH_EN
          end else if (mag1 < mag2) begin
            // END raises ready one edge later, giving the same 2-edge latency as divide-by-zero
            state_d  = S_END;
            result_d = {opdata1_i, 32'd0};
`endif
          end else begin
            state_d = S_BUSY;
          end
        end
      end
      S_DIVZERO: begin
        state_d  = annul_i ? S_IDLE : S_END;
        result_d = 64'd0;
        ready_d  = !annul_i;
      end
      S_BUSY: begin
        if (annul_i) begin
          state_d  = S_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else if (cnt_q == 6'd32) begin
          state_d  = S_END;
          result_d = {neg_if(neg1_q, rem_q), neg_if(neg1_q ^ neg2_q, dq_q)};
          ready_d  = 1'b1;
        end else begin
          rem_d = ge ? (rem_sh[31:0] - dvsr_q) : rem_sh[31:0];
          dq_d  = {dq_q[30:0], ge};
          cnt_d = cnt_q + 6'd1;
        end
      end
      S_END: begin
        if (annul_i || !start_i) begin
          state_d  = S_IDLE;
          result_d = 64'd0;
          ready_d  = 1'b0;
        end else begin
          ready_d = 1'b1;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q  <= S_IDLE;
      cnt_q    <= 6'd0;
      dq_q     <= 32'd0;
      dvsr_q   <= 32'd0;
      rem_q    <= 32'd0;
      neg1_q   <= 1'b0;
      neg2_q   <= 1'b0;
      result_q <= 64'd0;
      ready_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      dq_q     <= dq_d;
      dvsr_q   <= dvsr_d;
      rem_q    <= rem_d;
      neg1_q   <= neg1_d;
      neg2_q   <= neg2_d;
      result_q <= result_d;
      ready_q  <= ready_d;
    end
  end

  assign result_o = result_q;
  assign ready_o  = ready_q;

endmodule

// File: tb/tb_div_iter.sv
// Directed bench for div_iter: latency, signed/unsigned results, divide-by-zero, annul, reset.
module tb_div_iter;

  logic        clk = 1'b0;
  logic        resetn;
  logic        signed_div;
  logic [31:0] op1, op2;
  logic        start, annul;
  logic [63:0] result;
  logic        ready;

  int n_tests = 0;
  int n_fail  = 0;
  int fp_lat;

  always #5 clk = ~clk;

  div_iter dut (
    .clk         (clk),
    .resetn      (resetn),
    .signed_div_i(signed_div),
    .opdata1_i   (op1),
    .opdata2_i   (op2),
    .start_i     (start),
    .annul_i     (annul),
    .result_o    (result),
    .ready_o     (ready)
  );

  // Issue one division, scramble inputs after the accepting edge, drop start on ready.
  task automatic run_div(input logic [31:0] a, input logic [31:0] b, input logic s,
                         output int edges, output logic [63:0] res);
    op1 = a; op2 = b; signed_div = s; start = 1'b1;
    edges = 0;
    res = '0;
    while (edges < 200) begin
      @(posedge clk); #1;
      edges++;
      if (edges == 1) begin
        op1 = ~a; op2 = ~b; signed_div = ~s;
      end
      if (ready) break;
    end
    res = result;
    start = 1'b0;
  endtask

  task automatic test_reset();
    resetn = 1'b0; start = 1'b0; annul = 1'b0; signed_div = 1'b0; op1 = '0; op2 = '0;
    repeat (2) @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset: ready=%b result=%h, want 0/0", ready, result);
    end
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_unsigned();
    int e; logic [63:0] r;
    run_div(32'd100, 32'd7, 1'b0, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000002_0000000E) begin
      n_fail++;
      $display("FAIL udiv_100_7: edges=%0d result=%h, want 34 00000002_0000000e", e, r);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL ready_one_cycle: ready=%b result=%h, want 0/0", ready, result);
    end
    run_div(32'hFFFFFFFF, 32'h10, 1'b0, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h0000000F_0FFFFFFF) begin
      n_fail++;
      $display("FAIL udiv_max_16: edges=%0d result=%h, want 34 0000000f_0fffffff", e, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_signed();
    int e; logic [63:0] r;
    run_div(32'hFFFFFFF9, 32'h2, 1'b1, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'hFFFFFFFF_FFFFFFFD) begin
      n_fail++;
      $display("FAIL sdiv_m7_2: edges=%0d result=%h, want 34 ffffffff_fffffffd", e, r);
    end
    @(posedge clk); #1;
    run_div(32'h7, 32'hFFFFFFFE, 1'b1, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000001_FFFFFFFD) begin
      n_fail++;
      $display("FAIL sdiv_7_m2: edges=%0d result=%h, want 34 00000001_fffffffd", e, r);
    end
    @(posedge clk); #1;
    run_div(32'hFFFFFF9C, 32'hFFFFFFF9, 1'b1, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'hFFFFFFFE_0000000E) begin
      n_fail++;
      $display("FAIL sdiv_m100_m7: edges=%0d result=%h, want 34 fffffffe_0000000e", e, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_divzero();
    int e; logic [63:0] r;
    run_div(32'h1234, 32'h0, 1'b0, e, r);
    n_tests++;
    if (e !== 2 || r !== 64'd0) begin
      n_fail++;
      $display("FAIL divzero_u: edges=%0d result=%h, want 2 0", e, r);
    end
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b0) begin
      n_fail++;
      $display("FAIL divzero_drop: ready=%b, want 0", ready);
    end
    run_div(32'h80000000, 32'h0, 1'b1, e, r);
    n_tests++;
    if (e !== 2 || r !== 64'd0) begin
      n_fail++;
      $display("FAIL divzero_s: edges=%0d result=%h, want 2 0", e, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_overflow();
    int e; logic [63:0] r;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b1, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000000_80000000) begin
      n_fail++;
      $display("FAIL sdiv_min_m1: edges=%0d result=%h, want 34 00000000_80000000", e, r);
    end
    @(posedge clk); #1;
    run_div(32'h80000000, 32'hFFFFFFFF, 1'b0, e, r);
    n_tests++;
    if (e !== fp_lat || r !== 64'h80000000_00000000) begin
      n_fail++;
      $display("FAIL udiv_min_max: edges=%0d result=%h, want %0d 80000000_00000000", e, r, fp_lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_fast_path();
    int e; logic [63:0] r;
    run_div(32'd5, 32'd9, 1'b0, e, r);
    n_tests++;
    if (e !== fp_lat || r !== 64'h00000005_00000000) begin
      n_fail++;
      $display("FAIL small_5_9: edges=%0d result=%h, want %0d 00000005_00000000", e, r, fp_lat);
    end
    @(posedge clk); #1;
    run_div(32'hFFFFFFFB, 32'd9, 1'b1, e, r);
    n_tests++;
    if (e !== fp_lat || r !== 64'hFFFFFFFB_00000000) begin
      n_fail++;
      $display("FAIL small_m5_9: edges=%0d result=%h, want %0d fffffffb_00000000", e, r, fp_lat);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_end_hold();
    int e; logic [63:0] r;
    op1 = 32'd100; op2 = 32'd7; signed_div = 1'b0; start = 1'b1;
    e = 0;
    while (e < 200 && ready !== 1'b1) begin
      @(posedge clk); #1; e++;
    end
    repeat (3) @(posedge clk);
    #1;
    n_tests++;
    if (ready !== 1'b1 || result !== 64'h00000002_0000000E) begin
      n_fail++;
      $display("FAIL end_hold: ready=%b result=%h, want 1 00000002_0000000e", ready, result);
    end
    annul = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL annul_end: ready=%b result=%h, want 0/0", ready, result);
    end
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    // annul while in DIVZERO
    op1 = 32'd5; op2 = 32'd0; start = 1'b1;
    @(posedge clk); #1;
    annul = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL annul_divzero: ready=%b result=%h, want 0/0", ready, result);
    end
    annul = 1'b0; start = 1'b0;
    @(posedge clk); #1;
    r = '0;
    run_div(32'd20, 32'd6, 1'b0, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000002_00000003) begin
      n_fail++;
      $display("FAIL after_end_annul: edges=%0d result=%h, want 34 00000002_00000003", e, r);
    end
    @(posedge clk); #1;
  endtask

  task automatic test_annul();
    int e; int hits; logic [63:0] r;
    op1 = 32'hFFFFFFFF; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (11) @(posedge clk);
    #1;
    annul = 1'b1;
    @(posedge clk); #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL annul_busy: ready=%b result=%h, want 0/0", ready, result);
    end
    annul = 1'b0; start = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) hits++;
    end
    n_tests++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL annul_busy_quiet: ready seen %0d cycles, want 0", hits);
    end
    run_div(32'd9, 32'd3, 1'b0, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000000_00000003) begin
      n_fail++;
      $display("FAIL after_annul_9_3: edges=%0d result=%h, want 34 00000000_00000003", e, r);
    end
    @(posedge clk); #1;
    // annul in IDLE blocks acceptance
    op1 = 32'd100; op2 = 32'd7; start = 1'b1; annul = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    start = 1'b0; annul = 1'b0;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) hits++;
    end
    n_tests++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL annul_idle: ready seen %0d cycles, want 0", hits);
    end
  endtask

  task automatic test_reset_mid();
    int e; int hits; logic [63:0] r;
    op1 = 32'd1000; op2 = 32'd3; signed_div = 1'b0; start = 1'b1;
    repeat (10) @(posedge clk);
    #1;
    resetn = 1'b0; start = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_busy: ready=%b result=%h, want 0/0", ready, result);
    end
    @(posedge clk); #1;
    resetn = 1'b1;
    hits = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk); #1;
      if (ready === 1'b1) hits++;
    end
    n_tests++;
    if (hits !== 0) begin
      n_fail++;
      $display("FAIL reset_busy_quiet: ready seen %0d cycles, want 0", hits);
    end
    run_div(32'd20, 32'd6, 1'b0, e, r);
    n_tests++;
    if (e !== 34 || r !== 64'h00000002_00000003) begin
      n_fail++;
      $display("FAIL after_reset_20_6: edges=%0d result=%h, want 34 00000002_00000003", e, r);
    end
    @(posedge clk); #1;
    // asynchronous reset while a result is being held
    op1 = 32'd20; op2 = 32'd6; start = 1'b1;
    e = 0;
    while (e < 200 && ready !== 1'b1) begin
      @(posedge clk); #1; e++;
    end
    #2;
    resetn = 1'b0;
    #1;
    n_tests++;
    if (ready !== 1'b0 || result !== 64'd0) begin
      n_fail++;
      $display("FAIL reset_end: ready=%b result=%h, want 0/0", ready, result);
    end
    start = 1'b0;
    @(posedge clk); #1;
    resetn = 1'b1;
    @(posedge clk); #1;
  endtask

  initial begin
`ifdef DIV_FAST_PATH_EN
    fp_lat = 2;
`else
    fp_lat = 34;
`endif
    test_reset();
    test_unsigned();
    test_signed();
    test_divzero();
    test_overflow();
    test_fast_path();
    test_end_hold();
    test_annul();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/div_iter.md
# div_iter

Multi-cycle iterative 32-bit integer divider consumed by the execute stage for DIV/DIVU. The execute stage holds `start_i` and operands while the result is not ready, stalling the pipeline. Results are written to HI (remainder) and LO (quotient) on the cycle `ready_o` is seen. The core is a radix-2 restoring divider with a 4-state FSM, a 6-bit iteration counter, operand latching and signed pre- and post-correction.

## Interface
- No parameters; datapath fixed at 32 bits.
- `clk`  in  1  rising-edge clock
- `resetn`  in  1  asynchronous, active-low reset
- `signed_div_i`  in  1  1 = signed (DIV), 0 = unsigned (DIVU); sampled with `start_i`
- `opdata1_i`  in  32  dividend
- `opdata2_i`  in  32  divisor
- `start_i`  in  1  request; held high by execute stage until `ready_o` seen
- `annul_i`  in  1  abort the division in progress (pipeline flush)
- `result_o`  out  64  {remainder[31:0], quotient[31:0]}; valid only while `ready_o`=1
- `ready_o`  out  1  result valid

## Operation
- States: IDLE, DIVZERO, BUSY, END. Reset: IDLE, `ready_o`=0, `result_o`=0, counter=0, all datapath registers 0.
- **IDLE**
  - `start_i`=1 and `annul_i`=0: latch `signed_div_i`, both operands and their sign bits.
  - Divisor = 0: go to DIVZERO.
  - Otherwise go to BUSY with counter=0.
  - Magnitudes are loaded as two's-complement absolute values when signed and negative; unsigned otherwise.
- **DIVZERO**: go to END with `result_o`=0, `ready_o`=1.
- **BUSY**
  - Counter<32: shift the 33-bit partial remainder left, bringing in the next dividend MSB.
  - Trial subtract the zero-extended divisor magnitude. If non-negative, keep the difference and shift in quotient bit 1; else keep the remainder and shift in 0.
  - Counter increments each iteration.
  - Counter=32: apply sign correction and go to END with `ready_o`=1.
- **Sign correction** (signed only):
  - Quotient negated when dividend and divisor signs differ.
  - Remainder negated when the dividend is negative; remainder sign always follows the dividend.
  - 0x80000000 / 0xFFFFFFFF signed yields quotient 0x80000000, remainder 0.
- **END**: hold `result_o`, `ready_o`=1.
  - `start_i`=0: next edge returns to IDLE with `ready_o`=0 and `result_o`=0.
  - `start_i`=1: remain in END. A new division requires `start_i` low for at least one edge.
- **annul_i**:
  - High in BUSY or DIVZERO: next edge returns to IDLE, `ready_o`=0, `result_o`=0.
  - In IDLE it blocks acceptance of `start_i`.
  - In END it forces IDLE.
- Input changes after the start edge are ignored; all operands are latched. Dropping `start_i` during BUSY does not abort; only `annul_i` or reset aborts.
- `resetn` low at any time, mid-division included: immediate return to reset values.

## Timing
- All outputs registered; no combinational input-to-output path.
- Normal latency: `ready_o` rises after the 34th rising edge counting the accepting edge (1 accept, 32 iterations, 1 correction). The execute stage therefore stalls 34 cycles.
- Divide-by-zero: `ready_o` rises after the 2nd edge.
- `ready_o` is high for exactly one cycle when the execute stage drops `start_i` combinationally on `ready_o`, as it does.
- Back-to-back divisions: the next accept occurs no earlier than the edge after the return to IDLE.

## Configuration
- `DIV_FAST_PATH_EN`
  - Defined: in IDLE with non-zero divisor, if dividend magnitude < divisor magnitude (unsigned compare of absolute values), go directly to END. Result: quotient 0, remainder = the original signed dividend, latency 2.
  - Undefined: no fast path; every non-zero divisor takes the 34-cycle path with identical results.

## Test plan
- Unsigned 100 / 7, start held: `ready_o` after 34 edges, `result_o`=0x00000002_0000000E. One cycle later `ready_o`=0.
- Signed -7 / 2 (0xFFFFFFF9 / 0x2): quotient 0xFFFFFFFD, remainder 0xFFFFFFFF. Signed 7 / -2: quotient 0xFFFFFFFD, remainder 0x00000001.
- Divisor 0 (any dividend): `ready_o` after 2 edges, `result_o`=0. Signed 0x80000000 / 0xFFFFFFFF: quotient 0x80000000, remainder 0.
- Start 0xFFFFFFFF / 3 unsigned, assert `annul_i` at iteration 10: next edge IDLE with `ready_o`=0. A new request 9 / 3 then yields quotient 3, remainder 0 after 34 edges.
- Pull `resetn` low mid-BUSY: outputs 0 immediately. After release, 20 / 6 gives quotient 3, remainder 2.
- `DIV_FAST_PATH_EN` on: 5 / 9 gives `ready_o` at edge 2, quotient 0, remainder 5. Off: same result at edge 34.
